stopwatch_display_scan: RTL
===========================

// Module: stopwatch_display_scan
// PURPOSE
//   Consumer side of the stopwatch result interface (minutes/seconds/status).
//   Converts the counter values to decimal and drives a 4-digit, time-multiplexed,
//   common-anode 7-segment display as MM:SS. Digit 2's decimal point is the colon.
//   Instantiated next to the stopwatch core; its outputs go straight to board pins.
// PARAMETERS
//   DIGIT_PERIOD  1000        clk cycles per digit slot (>=2)
//   BLINK_PERIOD  25_000_000  clk cycles per blink half-period in PAUSED (>=2)
// PORTS
//   clk      in   1  system clock, single domain
//   rst_n    in   1  asynchronous, active-low reset
//   minutes  in   8  binary minutes from stopwatch core
//   seconds  in   6  binary seconds, legal range 0..59
//   status   in   2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 invalid
//   an_n     out  4  digit enables, active-low; bit0 = rightmost digit (seconds units)
//   seg_n    out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp_n     out  1  decimal point (colon), active-low
// BEHAVIOUR
// - Reset (async assert, sync deassert by design): an_n=4'b1111, seg_n=7'h7F, dp_n=1,
//   prescaler=0, digit index=0, blink counter=0, blink phase=visible, shadow regs=0/IDLE.
// - Prescaler counts 0..DIGIT_PERIOD-1. At terminal count, digit index advances 0->1->2->3->0.
// - Snapshot: when index wraps 3->0, and on the first slot after reset, latch
//   minutes/seconds/status into shadow regs. All four digits of one frame come from one
//   snapshot, so there is no tearing.
// - Anti-ghosting: on prescaler==0 of every slot, an_n=4'b1111. On the remaining cycles,
//   an_n has bit[index] low. seg_n/dp_n are registered; they update on the same edge as an_n.
// - Digit values: 0 = sec%10, 1 = sec/10, 2 = min%10, 3 = min/10 (from shadow regs).
// - Out of range: shadow minutes>99 -> digits 3,2 show dash (7'b0111111).
//   Shadow seconds>59 -> digits 1,0 show dash.
// - Status rendering:
//   - IDLE: digits on, colon off.
//   - RUNNING: digits on, colon on steadily (dp_n=0 during digit-2 slot only).
//   - PAUSED: digits and colon blink. During the hidden phase an_n=4'b1111 for the whole slot.
//   - 11: all four digits show dash, colon off.
// - Blink: counter counts 0..BLINK_PERIOD-1 and toggles the phase at terminal count.
//   It is cleared, with phase set to visible, on the cycle the live status input changes
//   to PAUSED, so a pause is visible immediately. Phase is ignored outside PAUSED.
// - Decimal conversion is combinational from shadow regs (value<100: tens=v/10, units=v%10),
//   followed by segment decode and the output register. Latency from snapshot to pins is
//   <=1 slot plus 1 cycle.
// - Async reset mid-scan: outputs blank immediately and the scan restarts at digit 0.
// STRUCTURE
// - stopwatch_pkg holds: ST_IDLE/ST_RUNNING/ST_PAUSED/ST_INVALID encodings,
//   SEG_BLANK=7'h7F, SEG_DASH=7'h3F, and the 0..9 active-low segment table.
// - Sub-module seg7_decoder (combinational): 4-bit digit plus dash flag -> seg_n.
// - This module owns the prescaler, digit index, snapshot regs, blink FSM
//   (VISIBLE/HIDDEN) and output registers.
// TESTING (bench: DIGIT_PERIOD=4, BLINK_PERIOD=16)
// 1. Reset held, then released, status=IDLE, 00/00:
//    an_n=1111 during reset. First slot shows an_n=1110, seg_n=7'h40 ('0'), dp_n=1.
// 2. minutes=12, seconds=34, RUNNING:
//    scan gives digits 0..3 = '4'(7'h19), '3'(7'h30), '2'(7'h24), '1'(7'h79);
//    dp_n=0 only while an_n=1011.
//    Every slot's first cycle has an_n=1111.
// 3. seconds 34->35 while digit index=1:
//    digit 1 of the current frame still shows '3' and digit 0 shows '4'; the next frame shows 35.
// 4. RUNNING->PAUSED:
//    display visible for 16 cycles, then an_n=1111 for 16 cycles, repeating.
//    Returning to RUNNING gives a steady display.
// 5. minutes=150, seconds=7: digits 3,2 show 7'h3F, digit 1 '0', digit 0 '7'.
//    status=11 shows all dashes.
// 6. rst_n asserted mid-slot at index 2: outputs blank in the same cycle (asynchronous).
//    After release, scanning restarts at an_n=1110.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings, segment patterns and decimal split helper for the stopwatch display.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_INVALID = 2'b11
  } status_e;

  typedef enum logic {
    BL_VISIBLE = 1'b0,
    BL_HIDDEN  = 1'b1
  } blink_e;

  typedef struct packed {
    logic [7:0] minutes;
    logic [5:0] seconds;
    status_e    status;
  } snap_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_DASH   = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; entry [0] is the pattern for '0'.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // {tens, units}; only meaningful for v < 100, callers dash anything larger.
  function automatic logic [7:0] split_dec(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 8'd10);
    units = 4'(v % 8'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One digit of BCD (plus dash override) to active-low 7-segment pattern.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    if (dash)
      seg_n = SEG_DASH;
    else if (digit <= 4'd9)
      seg_n = SEG_TABLE[digit];
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Time-multiplexed MM:SS driver for a 4-digit common-anode display, with
// frame snapshots, anti-ghost blanking and a pause blink.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int DIGIT_PERIOD = 1000,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int PW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int BW = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

  logic [PW-1:0] presc, nxt_presc;
  logic [1:0]    idx, nxt_idx;
  logic          presc_tc, snap, first_slot;
  snap_t         shadow, nxt_shadow, live;
  logic [BW-1:0] blink_cnt, nxt_blink_cnt;
  blink_e        phase, nxt_phase;
  status_e       status_q;
  logic          pause_enter;

  // Outputs are built from next-cycle state so an_n lines up with presc/idx.
  always_comb begin
    presc_tc   = (presc == PW'(DIGIT_PERIOD - 1));
    nxt_presc  = presc_tc ? '0 : presc + 1'b1;
    nxt_idx    = presc_tc ? idx + 2'd1 : idx;
    snap       = first_slot || (presc_tc && idx == 2'd3);
    live         = '0;
    live.minutes = minutes;
    live.seconds = seconds;
    live.status  = status_e'(status);
    nxt_shadow = snap ? live : shadow;
  end

  always_comb begin
    pause_enter   = (status_e'(status) == ST_PAUSED) && (status_q != ST_PAUSED);
    nxt_blink_cnt = blink_cnt + 1'b1;
    nxt_phase     = phase;
    if (pause_enter) begin
      nxt_blink_cnt = '0;
      nxt_phase     = BL_VISIBLE;
    end else if (blink_cnt == BW'(BLINK_PERIOD - 1)) begin
      nxt_blink_cnt = '0;
      nxt_phase     = (phase == BL_VISIBLE) ? BL_HIDDEN : BL_VISIBLE;
    end
  end

  logic [NUM_DIGITS-1:0][3:0] dig_val;
  logic [NUM_DIGITS-1:0]      dig_dash;
  logic [NUM_DIGITS-1:0][6:0] dig_seg;
  logic [7:0]                 sec_dec, min_dec;
  logic                       invalid, sec_oor, min_oor;

  always_comb begin
    sec_dec  = split_dec({2'b00, nxt_shadow.seconds});
    min_dec  = split_dec(nxt_shadow.minutes);
    invalid  = (nxt_shadow.status == ST_INVALID);
    sec_oor  = (nxt_shadow.seconds > 6'd59);
    min_oor  = (nxt_shadow.minutes > 8'd99);
    dig_val  = {min_dec[7:4], min_dec[3:0], sec_dec[7:4], sec_dec[3:0]};
    dig_dash = {{2{invalid | min_oor}}, {2{invalid | sec_oor}}};
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg7_decoder u_dec (
      .digit (dig_val[g]),
      .dash  (dig_dash[g]),
      .seg_n (dig_seg[g])
    );
  end

  logic blank, hidden, colon;

  always_comb begin
    hidden = (nxt_shadow.status == ST_PAUSED) && (nxt_phase == BL_HIDDEN);
    blank  = (nxt_presc == '0) || hidden;
    colon  = (nxt_idx == 2'd2) &&
             (nxt_shadow.status == ST_RUNNING || nxt_shadow.status == ST_PAUSED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      first_slot <= 1'b1;
      shadow     <= '0;
      blink_cnt  <= '0;
      phase      <= BL_VISIBLE;
      status_q   <= ST_IDLE;
      an_n       <= 4'hF;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
    end else begin
      presc      <= nxt_presc;
      idx        <= nxt_idx;
      first_slot <= 1'b0;
      shadow     <= nxt_shadow;
      blink_cnt  <= nxt_blink_cnt;
      phase      <= nxt_phase;
      status_q   <= status_e'(status);
      an_n       <= blank ? 4'hF : ~(4'b0001 << nxt_idx);
      seg_n      <= blank ? SEG_BLANK : dig_seg[nxt_idx];
      dp_n       <= blank ? 1'b1 : ~colon;
    end
  end

endmodule
